// File: rtl/karat_div_iterative_pkg.sv
// Shared types and width helpers for the iterative Karatsuba divider and its benches.
package karat_div_iterative_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_t;

  localparam int KD_WI_DEFAULT = 1024;
  localparam int KD_WO_DEFAULT = 2 * KD_WI_DEFAULT;

  // Ceiling log2, clamped to 1 so a counter never collapses to zero width.
  function automatic int clog2_w(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/karat_div_iterative_if.sv
// Start/result bus of the iterative divider; matches the multiplier's enable/finish style.
interface karat_div_iterative_if #(
  parameter int wI = 1024,
  parameter int wO = 2 * wI
);
  logic          i_enable;
  logic [wO-1:0] iN;
  logic [wI-1:0] iD;
  logic [wO-1:0] oQ;
  logic [wI-1:0] oR;
  logic          o_busy;
  logic          o_finish;
  logic          o_dbz;

  modport master (
    output i_enable, iN, iD,
    input  oQ, oR, o_busy, o_finish, o_dbz
  );

  modport slave (
    input  i_enable, iN, iD,
    output oQ, oR, o_busy, o_finish, o_dbz
  );
endinterface

// File: rtl/karat_div_iterative_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module karat_div_step #(
  parameter int wI = 1024
) (
  input  logic [wI:0]   rem_in,
  input  logic          bit_in,
  input  logic [wI-1:0] d,
  output logic [wI:0]   rem_out,
  output logic          q_bit
);
  logic [wI:0] w_t;
  logic [wI:0] w_d_ext;
  logic        w_ge;
  logic        w_unused_msb;

  // The incoming remainder is always below d, so its top bit is known zero.
  assign w_unused_msb = rem_in[wI];

  assign w_t     = {rem_in[wI-1:0], bit_in};
  assign w_d_ext = {1'b0, d};
  assign w_ge    = (w_t >= w_d_ext);
  assign rem_out = w_ge ? (w_t - w_d_ext) : w_t;
  assign q_bit   = w_ge;
endmodule

// File: rtl/karat_div_iterative.sv
// Sequential radix-2 restoring divider: wO-bit dividend by wI-bit divisor, one quotient bit per clock.
module karat_div_iterative
  import karat_div_iterative_pkg::*;
#(
  parameter int wI = 1024,
  parameter int wO = 2 * wI
) (
  input  logic                  clk,
  input  logic                  rst_n,
  karat_div_iterative_if.slave  bus
);
  localparam int              wCNT     = clog2_w(wO);
  localparam logic [wCNT-1:0] CNT_LAST = wCNT'(wO - 1);

  div_state_t    r_state;
  div_state_t    w_next;
  logic [wCNT-1:0] r_cnt;
  logic [wO-1:0] r_n;
  logic [wO-1:0] r_q;
  logic [wI-1:0] r_d;
  logic [wI:0]   r_rem;
  logic [wO-1:0] r_oq;
  logic [wI-1:0] r_or;
  logic          r_busy;
  logic          r_finish;
  logic          r_dbz;

  logic [wI:0]   w_rem;
  logic          w_qbit;
  logic          w_accept;
  logic          w_dbz_start;
  logic          w_last;
  logic [wO-1:0] w_q_shift;

  karat_div_step #(.wI(wI)) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_n[wO-1]),
    .d       (r_d),
    .rem_out (w_rem),
    .q_bit   (w_qbit)
  );

  assign w_q_shift = {r_q[wO-2:0], w_qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_dbz_start = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_enable) begin
          if (bus.iD != '0) begin
            w_accept = 1'b1;
            w_next   = CALC;
          end else begin
            w_dbz_start = 1'b1;
          end
        end
      end
      CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_last = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_n      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_rem    <= '0;
      r_oq     <= '0;
      r_or     <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (w_accept) begin
        r_n    <= bus.iN;
        r_d    <= bus.iD;
        r_rem  <= '0;
        r_q    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
      // Divide-by-zero completes on the accepting edge without entering CALC.
      if (w_dbz_start) begin
        r_oq     <= '1;
        r_or     <= bus.iN[wI-1:0];
        r_dbz    <= 1'b1;
        r_finish <= 1'b1;
      end
      if (r_state == CALC) begin
        r_rem <= w_rem;
        r_n   <= r_n << 1;
        r_q   <= w_q_shift;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_cnt    <= '0;
          r_oq     <= w_q_shift;
          r_or     <= w_rem[wI-1:0];
          r_dbz    <= 1'b0;
          r_finish <= 1'b1;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  assign bus.oQ       = r_oq;
  assign bus.oR       = r_or;
  assign bus.o_busy   = r_busy;
  assign bus.o_finish = r_finish;
  assign bus.o_dbz    = r_dbz;
endmodule

// File: tb/tb_karat_div_iterative.sv
// Directed and random checks of karat_div_iterative at wI=8, wO=16 against a cycle-level arithmetic model.
module tb_karat_div_iterative;
  localparam int WI = 8;
  localparam int WO = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  karat_div_iterative_if #(.wI(WI), .wO(WO)) bus ();

  karat_div_iterative #(.wI(WI), .wO(WO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request completes WO edges later with plain / and %.
  int            m_left;
  logic          m_fin;
  logic [WO-1:0] m_q;
  logic [WI-1:0] m_r;
  logic          m_dbz;
  int            m_n;
  int            m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_fin  = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
      m_n    = 0;
      m_d    = 0;
    end else begin
      m_fin = 1'b0;
      if (m_left == 0) begin
        if (bus.i_enable) begin
          if (bus.iD == 0) begin
            m_q   = '1;
            m_r   = bus.iN[WI-1:0];
            m_dbz = 1'b1;
            m_fin = 1'b1;
          end else begin
            m_left = WO;
            m_n    = int'(bus.iN);
            m_d    = int'(bus.iD);
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_q   = WO'(m_n / m_d);
          m_r   = WI'(m_n % m_d);
          m_dbz = 1'b0;
          m_fin = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("finish", 64'(bus.o_finish), 64'(m_fin));
    check("busy",   64'(bus.o_busy),   64'(m_left != 0));
    check("q",      64'(bus.oQ),       64'(m_q));
    check("r",      64'(bus.oR),       64'(m_r));
    check("dbz",    64'(bus.o_dbz),    64'(m_dbz));
    if (bus.o_finish && !bus.o_dbz) begin
      check("invariant", 64'(bus.oQ) * 64'(m_d) + 64'(bus.oR), 64'(m_n));
      check("rem_lt_d",  64'(int'(bus.oR) < m_d), 64'd1);
    end
  end

  task automatic wait_fin(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.o_finish && cycles < 60);
    if (!bus.o_finish) check("finish_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input logic [WO-1:0] n, input logic [WI-1:0] d,
                     input logic [WO-1:0] eq, input logic [WI-1:0] er,
                     input logic edbz, input int elat);
    int lat;
    @(negedge clk);
    bus.i_enable = 1'b1;
    bus.iN       = n;
    bus.iD       = d;
    @(negedge clk);
    bus.i_enable = 1'b0;
    lat = 1;
    while (!bus.o_finish && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    check("lit_q",   64'(bus.oQ), 64'(eq));
    check("lit_r",   64'(bus.oR), 64'(er));
    check("lit_dbz", 64'(bus.o_dbz), 64'(edbz));
  endtask

  initial begin
    int c;
    logic [WO-1:0] rn;
    logic [WI-1:0] rd;
    logic [WI-1:0] ra;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_enable = 1'b0;
    bus.iN = '0;
    bus.iD = '0;
    repeat (3) @(negedge clk);
    check("rst_q",      64'(bus.oQ), 64'd0);
    check("rst_finish", 64'(bus.o_finish), 64'd0);
    check("rst_busy",   64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;

    run(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, WO + 1);
    run(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, WO + 1);
    run(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, WO + 1);
    run(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1);

    // Held enable: each new request is taken on the edge that ends the finish cycle.
    @(negedge clk);
    bus.i_enable = 1'b1;
    bus.iN = 16'd50000;
    bus.iD = 8'd123;
    repeat (8) @(negedge clk);
    bus.iN = 16'hDEAD;
    bus.iD = 8'd3;
    wait_fin(c);
    check("b2b_lat0", 64'(c + 8), 64'(WO + 1));
    check("b2b_q0", 64'(bus.oQ), 64'd406);
    check("b2b_r0", 64'(bus.oR), 64'd62);
    bus.iN = 16'd65535;
    bus.iD = 8'd2;
    wait_fin(c);
    check("b2b_lat1", 64'(c), 64'(WO + 1));
    check("b2b_q1", 64'(bus.oQ), 64'd32767);
    bus.iN = 16'd300;
    bus.iD = 8'd255;
    wait_fin(c);
    check("b2b_lat2", 64'(c), 64'(WO + 1));
    check("b2b_r2", 64'(bus.oR), 64'd45);
    bus.i_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    bus.i_enable = 1'b1;
    bus.iN = 16'd1000;
    bus.iD = 8'd7;
    @(negedge clk);
    bus.i_enable = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(bus.o_busy), 64'd0);
    check("abort_finish", 64'(bus.o_finish), 64'd0);
    check("abort_q",      64'(bus.oQ), 64'd0);
    check("abort_r",      64'(bus.oR), 64'd0);
    check("abort_dbz",    64'(bus.o_dbz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, WO + 1);

    for (int i = 0; i < 120; i++) begin
      ra = WI'($urandom_range(0, 255));
      rd = WI'($urandom_range(1, 255));
      rn = WO'(int'(ra) * int'(rd));
      run(rn, rd, WO'(ra), 8'd0, 1'b0, WO + 1);
    end
    for (int i = 0; i < 60; i++) begin
      rn = WO'($urandom_range(0, 65535));
      rd = WI'($urandom_range(1, 255));
      run(rn, rd, WO'(int'(rn) / int'(rd)), WI'(int'(rn) % int'(rd)), 1'b0, WO + 1);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
